// File: rtl/sdram_arbiter.sv
// sdram_arbiter: one-outstanding-read arbiter sharing an SDRAM port among N_REQ readers and IOCTL download.
// Define SDRAM_ARB_AGING_EN to add per-requester starvation aging; otherwise strict fixed priority.
module sdram_arbiter #(
   parameter int N_REQ        = 4,
   parameter int ADDR_WIDTH   = 23,
   parameter int STARVE_LIMIT = 8,
   parameter int TIMEOUT      = 255
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              req,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   addr,
   output logic [N_REQ-1:0]              ack,
   output logic [N_REQ-1:0]              valid,
   input  logic                          download,
   input  logic                          dl_req,
   input  logic [ADDR_WIDTH-1:0]         dl_addr,
   output logic                          sdram_req,
   output logic [ADDR_WIDTH-1:0]         sdram_addr,
   output logic                          sdram_we,
   input  logic                          sdram_ack,
   input  logic                          sdram_valid,
   output logic                          timeout_err
);
   localparam int GW = N_REQ > 1 ? $clog2(N_REQ) : 1;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DL} state_t;
   state_t state_q, state_d;
   logic [GW-1:0] grant_q, grant_d, pick;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, pick_addr;
   logic [15:0] cnt_q, cnt_d;
   logic err_q, err_d, dl_q;
   logic [N_REQ-1:0] prom;
   logic grab;
   assign grab = state_q == IDLE && !download && |req;
   assign timeout_err = err_q;
`ifdef SDRAM_ARB_AGING_EN
   logic [7:0] starve_q [N_REQ];
   // Losers saturate at the limit; the winner and idle requesters restart from zero.
   always_ff @(posedge clk or posedge reset)
      if (reset)
         for (int i = 0; i < N_REQ; i++) starve_q[i] <= '0;
      else if (grab)
         for (int i = 0; i < N_REQ; i++)
            starve_q[i] <= (!req[i] || GW'(i) == pick) ? 8'd0 :
                           (starve_q[i] == 8'(STARVE_LIMIT)) ? starve_q[i] : starve_q[i] + 8'd1;
   always_comb begin
      prom = '0;
      for (int i = 0; i < N_REQ; i++) prom[i] = req[i] && starve_q[i] == 8'(STARVE_LIMIT);
   end
`else
   assign prom = '0;
`endif
   // Promoted requesters override plain fixed priority; lowest index wins within each group.
   always_comb begin
      pick = '0;
      pick_addr = addr[ADDR_WIDTH-1:0];
      for (int i = N_REQ-1; i >= 0; i--)
         if (req[i]) begin
            pick = GW'(i);
            pick_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      if (|prom)
         for (int i = N_REQ-1; i >= 0; i--)
            if (prom[i]) begin
               pick = GW'(i);
               pick_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
   end
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      addr_d = addr_q;
      cnt_d = cnt_q;
      err_d = (download && !dl_q) ? 1'b0 : err_q;
      ack = '0;
      valid = '0;
      sdram_req = 1'b0;
      sdram_addr = addr_q;
      sdram_we = 1'b0;
      case (state_q)
         IDLE:
            if (download) state_d = DL;
            else if (grab) begin
               state_d = REQ;
               grant_d = pick;
               addr_d = pick_addr;
            end
         REQ: begin
            sdram_req = 1'b1;
            if (sdram_ack) begin
               ack[grant_q] = 1'b1;
               cnt_d = '0;
               state_d = WAIT;
            end
         end
         WAIT:
            if (sdram_valid) begin
               valid[grant_q] = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == 16'(TIMEOUT-1)) begin
               err_d = 1'b1;
               state_d = IDLE;
            end else cnt_d = cnt_q + 16'd1;
         DL: begin
            sdram_req = dl_req;
            sdram_addr = dl_addr;
            sdram_we = 1'b1;
            if (!download) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         addr_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
         dl_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q <= addr_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
         dl_q <= download;
      end
endmodule
